serial_receiver: RTL and testbench
==================================

SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 434, clock cycles per serial bit period (115200 baud at 50 MHz); legal range 4..65535.
REQ-002 Port: clk_clk  input  1  sole clock; all flops on rising edge.
REQ-003 Port: reset_reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: serial_in  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-005 Port: char_ack  input  1  one-cycle acknowledge from processor PIO; clears received/error flags.
REQ-006 Port: parallel_out  output  8  last correctly framed received byte; feeds processor parallel input PIO.
REQ-007 Port: character_received  output  1  sticky flag: new byte valid in parallel_out.
REQ-008 Port: framing_error  output  1  sticky flag: stop bit sampled low.
REQ-009 Port: overrun  output  1  sticky flag: byte completed while character_received still set.
REQ-010 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-011 serial_in SHALL pass through a 2-flop synchronizer (reset value 1); all logic uses the synchronized value rx_s.
REQ-012 FSM states: IDLE, START, DATA, STOP; 16-bit bit-period counter; 3-bit bit index.
REQ-013 IDLE: rx_s==0 at cycle T0 -> START, counter cleared.
REQ-014 START: at T0+CLKS_PER_BIT/2 (integer divide) sample rx_s; 0 -> DATA, 1 -> IDLE (glitch rejected, no flags change).
REQ-015 DATA: bit i (0..7) sampled at T0+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT, shifted into MSB of shift register (shift right), so byte is LSB first.
REQ-016 After bit 7 -> STOP; stop sample at T0+CLKS_PER_BIT/2+9*CLKS_PER_BIT.
REQ-017 Stop sample 1: on the next edge parallel_out <= shift register, character_received <= 1; state -> IDLE.
REQ-018 Stop sample 0: parallel_out and character_received unchanged, framing_error <= 1; state -> IDLE.
REQ-019 Return to IDLE occurs at mid-stop-bit; a new start edge detected from the following cycle onward is accepted (back-to-back frames).
REQ-020 char_ack high for a cycle -> character_received, framing_error, overrun cleared next edge, unless a flag-set event occurs in the same cycle.
REQ-021 Good byte completes while character_received==1 and char_ack==0 -> parallel_out overwritten, overrun <= 1.
REQ-022 Good byte completes in same cycle as char_ack==1 -> character_received stays 1, parallel_out updated, overrun cleared (not set).
REQ-023 Framing error in same cycle as char_ack==1 -> framing_error ends at 1.
REQ-024 char_ack has no effect on FSM, counter or shift register.
REQ-025 busy SHALL be combinational from state (0 only in IDLE).

Reset
REQ-026 reset_reset_n low SHALL immediately force: state IDLE, counter 0, bit index 0, shift register 0x00, synchronizer 1,1, parallel_out 0x00, character_received 0, framing_error 0, overrun 0, busy 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no flag set; after release the receiver waits for a fresh falling edge (a line held low at release is treated as a start edge).
REQ-028 Reset release SHALL be synchronized externally; block requires no extra release logic.

Verification (CLKS_PER_BIT=4)
REQ-029 Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> parallel_out=0xA5, character_received=1 one cycle after stop sample (T0+38), framing_error=0.
REQ-030 Frame 0x3C with stop bit 0 -> framing_error=1, character_received=0, parallel_out keeps prior value 0x00.
REQ-031 0x11 then 0x22 back-to-back, no char_ack -> parallel_out=0x22, character_received=1, overrun=1; one char_ack pulse -> all flags 0, parallel_out=0x22.
REQ-032 Low glitch of 1 cycle on idle line -> START entered, rejected at mid-sample, busy returns 0, no flags, parallel_out unchanged.
REQ-033 char_ack asserted exactly on completion edge of second byte -> character_received=1, overrun=0.
REQ-034 reset_reset_n pulsed low during bit 4 of 0xFF -> all outputs reset values; subsequent 0x5A frame received correctly.

Source files
------------

// File: rtl/serial_receiver.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, and sticky
// received / framing-error / overrun flags cleared by a one-cycle char_ack.
module serial_receiver #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       serial_in,
  input  logic       char_ack,
  output logic [7:0] parallel_out,
  output logic       character_received,
  output logic       framing_error,
  output logic       overrun,
  output logic       busy
);

  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2) - 16'd1;
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT) - 16'd1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  po_q, po_d;
  logic        cr_q, cr_d;
  logic        fe_q, fe_d;
  logic        ov_q, ov_d;
  logic        rx_s;
  logic        good_ev, fe_ev;

  assign rx_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[0], serial_in};
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    po_d    = po_q;
    cr_d    = cr_q;
    fe_d    = fe_q;
    ov_d    = ov_q;
    good_ev = 1'b0;
    fe_ev   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = 16'd0;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = 16'd0;
          idx_d   = 3'd0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d = 16'd0;
          sh_d  = {rx_s, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = 16'd0;
          state_d = IDLE;
          good_ev = rx_s;
          fe_ev   = !rx_s;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // ack clears first so a same-cycle completion event wins
    if (char_ack) begin
      cr_d = 1'b0;
      fe_d = 1'b0;
      ov_d = 1'b0;
    end
    if (good_ev) begin
      po_d = sh_q;
      cr_d = 1'b1;
      if (cr_q && !char_ack) ov_d = 1'b1;
    end
    if (fe_ev) fe_d = 1'b1;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      sh_q    <= 8'h00;
      po_q    <= 8'h00;
      cr_q    <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      po_q    <= po_d;
      cr_q    <= cr_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  assign parallel_out       = po_q;
  assign character_received = cr_q;
  assign framing_error      = fe_q;
  assign overrun            = ov_q;
  assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_serial_receiver.sv
// Bench for serial_receiver: directed frames plus random frames, checked by a
// scoreboard of expected output tuples {parallel_out, received, ferr, overrun}.
module tb_serial_receiver;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       serial_in = 1'b1;
  logic       char_ack = 1'b0;
  logic [7:0] parallel_out;
  logic       character_received, framing_error, overrun, busy;

  int checks = 0;
  int errors = 0;

  serial_receiver #(.CLKS_PER_BIT(N)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .serial_in(serial_in),
    .char_ack(char_ack), .parallel_out(parallel_out),
    .character_received(character_received), .framing_error(framing_error),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: flag semantics only, no notion of FSM or timing.
  logic [7:0]  m_po = 8'h00;
  logic        m_cr = 1'b0, m_fe = 1'b0, m_ov = 1'b0;
  logic [10:0] last_exp = 11'h0;
  logic [10:0] exp_q[$];
  logic        mon_en = 1'b0;
  logic [10:0] prev = 11'h0;

  function automatic void m_push();
    logic [10:0] t;
    t = {m_po, m_cr, m_fe, m_ov};
    if (t != last_exp) begin
      exp_q.push_back(t);
      last_exp = t;
    end
  endfunction

  function automatic void m_frame(input logic [7:0] b, input logic stop, input logic ack);
    logic old_cr;
    old_cr = m_cr;
    if (ack) begin m_cr = 1'b0; m_fe = 1'b0; m_ov = 1'b0; end
    if (stop) begin
      m_ov = m_ov | (old_cr & !ack);
      m_po = b;
      m_cr = 1'b1;
    end else begin
      m_fe = 1'b1;
    end
    m_push();
  endfunction

  function automatic void m_ack();
    m_cr = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    m_push();
  endfunction

  function automatic void m_reset();
    m_po = 8'h00; m_cr = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    m_push();
  endfunction

  always @(negedge clk) begin
    logic [10:0] cur, e;
    if (mon_en) begin
      cur = {parallel_out, character_received, framing_error, overrun};
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output act=%h req=none", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL output_tuple act=%h req=%h", cur, e);
          end
        end
        prev = cur;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h", nm, act, req);
    end
  endtask

  // Drives a full frame; the line is still at stop level during the stop
  // sample cycle, which is where ack_at_end lands on the completion edge.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input logic ack_at_end, output logic cr_before);
    serial_in = 1'b0;
    tick(N);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      tick(N);
    end
    serial_in = stop;
    tick(N);
    cr_before = character_received;
    char_ack  = ack_at_end;
    tick(1);
    char_ack  = 1'b0;
    serial_in = 1'b1;
  endtask

  task automatic pulse_ack();
    char_ack = 1'b1;
    tick(1);
    char_ack = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string nm);
    int k;
    k = 0;
    while (busy !== lvl && k < budget) begin tick(1); k++; end
    chk(nm, busy, lvl);
  endtask

  initial begin
    logic       crb;
    logic [7:0] b;
    logic       st, ak;
    int         gap;

    #1;
    chk("reset_po", parallel_out, 8'h00);
    chk("reset_flags", {character_received, framing_error, overrun}, 3'b000);
    chk("reset_busy", busy, 1'b0);
    tick(3);
    rst_n = 1'b1;
    tick(3);
    mon_en = 1'b1;

    // Bad stop bit: only framing_error moves
    m_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, crb);
    tick(1);
    chk("ferr_set", {parallel_out, character_received, framing_error}, {8'h00, 2'b01});
    tick(2 * N);
    pulse_ack(); m_ack();
    tick(2);
    chk("ferr_ack", framing_error, 1'b0);

    // Good frame and exact completion latency
    m_frame(8'hA5, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0, crb);
    chk("a5_not_early", crb, 1'b0);
    chk("a5_on_time", {parallel_out, character_received, framing_error}, {8'hA5, 2'b10});
    tick(2);
    pulse_ack(); m_ack();
    tick(2);

    // Back-to-back without ack -> overrun, then one ack clears all
    m_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h11, 1'b1, 1'b0, crb);
    m_frame(8'h22, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, crb);
    chk("overrun_set", {parallel_out, character_received, overrun}, {8'h22, 2'b11});
    tick(2);
    pulse_ack(); m_ack();
    tick(1);
    chk("overrun_ack", {parallel_out, character_received, framing_error, overrun},
        {8'h22, 3'b000});

    // One-cycle glitch: START entered then rejected, nothing else moves
    serial_in = 1'b0;
    tick(1);
    serial_in = 1'b1;
    wait_busy(1'b1, 10, "glitch_busy_hi");
    wait_busy(1'b0, 10, "glitch_busy_lo");
    tick(2);
    chk("glitch_quiet", {parallel_out, character_received, framing_error, overrun},
        {8'h22, 3'b000});

    // Ack coincides with the completion edge of a second byte
    m_frame(8'h5C, 1'b1, 1'b0);
    send_frame(8'h5C, 1'b1, 1'b0, crb);
    m_frame(8'hC3, 1'b1, 1'b1);
    send_frame(8'hC3, 1'b1, 1'b1, crb);
    chk("ack_coinc", {parallel_out, character_received, overrun}, {8'hC3, 2'b10});
    tick(2);

    // Reset during bit 4 of 0xFF
    serial_in = 1'b0;
    tick(N);
    for (int i = 0; i < 4; i++) begin serial_in = 1'b1; tick(N); end
    tick(2);
    m_reset();
    rst_n = 1'b0;
    #2;
    chk("midreset_out", {parallel_out, character_received, framing_error, overrun, busy},
        {8'h00, 4'b0000});
    tick(2);
    rst_n = 1'b1;
    tick(3 * N);
    chk("midreset_idle", busy, 1'b0);
    m_frame(8'h5A, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, crb);
    chk("after_reset_5a", {parallel_out, character_received}, {8'h5A, 1'b1});
    tick(2);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      b  = 8'($urandom_range(0, 255));
      st = ($urandom_range(0, 4) != 0);
      m_frame(b, st, 1'b0);
      send_frame(b, st, 1'b0, crb);
      ak = ($urandom_range(0, 2) == 0);
      gap = st ? $urandom_range(0, 3) : 2 * N + $urandom_range(0, 3);
      if (ak) begin
        tick(1);
        pulse_ack(); m_ack();
      end
      if (gap > 0) tick(gap);
      if ($urandom_range(0, 7) == 0) begin
        serial_in = 1'b0;
        tick(1);
        serial_in = 1'b1;
        tick(2 * N);
      end
    end

    tick(10);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout act=running req=finished");
    $fatal(1);
  end
endmodule
